// File: rtl/timer_ctrl.sv
// Control FSM for the 32-bit step counter: one-shot/periodic timeouts, underflow guard, sticky irq.
// Optional build macro TIMER_CTRL_PRESCALE_EN adds a prescale divider on the counter enable.
module timer_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [2:0]       cfg_step,
    input  logic             cfg_dir,
    input  logic             cfg_periodic,
    input  logic             irq_ack,
`ifdef TIMER_CTRL_PRESCALE_EN
    input  logic [7:0]       prescale,
`endif
    input  logic [WIDTH-1:0] count,
    input  logic             timer_event,
    output logic             load,
    output logic [WIDTH-1:0] din,
    output logic [2:0]       mode,
    output logic             up_down,
    output logic [WIDTH-1:0] sat_count,
    output logic             enable,
    output logic             busy,
    output logic             irq,
    output logic             irq_overrun,
    output logic [CNT_W-1:0] event_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HIT} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] period_q;
    logic [2:0]       step_q;
    logic             dir_q;
    logic             periodic_q;
    logic [WIDTH-1:0] step_w;
    logic             expire;
    logic             accept;
    logic             tick;

    assign accept    = (state == IDLE) && start && !stop;
    assign step_w    = WIDTH'(step_q) + WIDTH'(1);
    // Guard: a down count below one step would wrap past zero on the next enable.
    assign expire    = timer_event || (!dir_q && (count < step_w));
    assign din       = dir_q ? '0 : period_q;
    assign mode      = step_q;
    assign up_down   = dir_q;
    assign sat_count = period_q;
    assign busy      = (state != IDLE);

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [7:0] pre_q;
    logic [7:0] div_q;

    assign tick = (div_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            div_q <= '0;
        end else begin
            if (accept)
                pre_q <= prescale;
            if (state == LOAD)
                div_q <= '0;
            else if (state == RUN)
                div_q <= (div_q == pre_q) ? '0 : div_q + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state;
        load    = 1'b0;
        enable  = 1'b0;
        case (state)
            IDLE: if (accept) state_d = LOAD;
            LOAD: begin
                load    = 1'b1;
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    enable = !expire && tick;
                    if (expire) state_d = HIT;
                end
            end
            HIT: begin
                if (stop)            state_d = IDLE;
                else if (periodic_q) state_d = LOAD;
                else                 state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            period_q    <= '0;
            step_q      <= '0;
            dir_q       <= 1'b0;
            periodic_q  <= 1'b0;
            irq         <= 1'b0;
            irq_overrun <= 1'b0;
            event_cnt   <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                period_q   <= cfg_period;
                step_q     <= cfg_step;
                dir_q      <= cfg_dir;
                periodic_q <= cfg_periodic;
            end
            // A set from an unaborted HIT takes priority over a coincident ack.
            if (state == HIT && !stop) begin
                event_cnt <= event_cnt + CNT_W'(1);
                irq       <= 1'b1;
                if (irq) irq_overrun <= 1'b1;
            end else if (irq_ack) begin
                irq         <= 1'b0;
                irq_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with a behavioural step-counter model closing the loop.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, irq_ack;
    logic [31:0] cfg_period;
    logic [2:0]  cfg_step;
    logic        cfg_dir, cfg_periodic;
    logic [31:0] count;
    logic        timer_event;
    logic        load, enable, busy, irq, irq_overrun, up_down;
    logic [31:0] din, sat_count;
    logic [2:0]  mode;
    logic [15:0] event_cnt;
`ifdef TIMER_CTRL_PRESCALE_EN
    logic [7:0]  prescale = 8'd0;
`endif

    typedef struct packed {
        logic        load;
        logic        enable;
        logic        busy;
        logic        irq;
        logic        ovr;
        logic [15:0] evc;
        logic [31:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    timer_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_period(cfg_period), .cfg_step(cfg_step), .cfg_dir(cfg_dir),
        .cfg_periodic(cfg_periodic), .irq_ack(irq_ack),
`ifdef TIMER_CTRL_PRESCALE_EN
        .prescale(prescale),
`endif
        .count(count), .timer_event(timer_event), .load(load), .din(din),
        .mode(mode), .up_down(up_down), .sat_count(sat_count), .enable(enable),
        .busy(busy), .irq(irq), .irq_overrun(irq_overrun), .event_cnt(event_cnt)
    );

    // Step counter model: load wins, then step by mode+1 in the selected direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      count <= '0;
        else if (load)   count <= din;
        else if (enable) count <= up_down ? count + 32'(mode) + 32'd1
                                          : count - 32'(mode) - 32'd1;
    end
    assign timer_event = up_down ? (count >= sat_count) : (count == 32'd0);

    function automatic obs_t mk(input bit ld, input bit en, input bit bsy,
                                input bit iq, input bit ov, input int evc, input int cnt);
        obs_t r;
        r.load = ld; r.enable = en; r.busy = bsy; r.irq = iq; r.ovr = ov;
        r.evc = evc[15:0]; r.cnt = cnt;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r.load = load; r.enable = enable; r.busy = busy; r.irq = irq;
        r.ovr = irq_overrun; r.evc = event_cnt; r.cnt = count;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_irq();
        tick(); irq_ack = 1'b1;
        tick(); irq_ack = 1'b0;
    endtask

    task automatic set_cfg(input int per, input int stp, input bit dir, input bit per_en);
        cfg_period = per; cfg_step = stp[2:0]; cfg_dir = dir; cfg_periodic = per_en;
    endtask

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
        set_cfg(0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_obs got=%h exp=%h", o, e); end
        n_cmp++;
        if ({din, mode, up_down, sat_count} !== '0) begin
            n_bad++; $display("FAIL reset_cfg got=%h exp=0", {din, mode, up_down, sat_count});
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_up_oneshot();
        obs_t o, e;
        set_cfg(5, 0, 1'b1, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            tick();
            start = (k == 0);
            exp_q.push_back(mk(k == 1, k >= 2 && k <= 6, k >= 1 && k <= 8, k == 9, 0,
                               (k == 9) ? 1 : 0, (k <= 2) ? 0 : ((k <= 7) ? k - 2 : 5)));
            #1;
            e = exp_q.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL up_oneshot k=%0d got=%h exp=%h", k, o, e); end
        end
    endtask

    task automatic test_down_guard();
        obs_t o, e;
        int   cnt;
        clear_irq();
        set_cfg(10, 2, 1'b0, 1'b0);
        for (int k = 0; k <= 7; k++) begin
            tick();
            start = (k == 0);
            if (k == 3) cfg_period = 99;
            case (k)
                0, 1:    cnt = 5;
                2:       cnt = 10;
                3:       cnt = 7;
                4:       cnt = 4;
                default: cnt = 1;
            endcase
            exp_q.push_back(mk(k == 1, k >= 2 && k <= 4, k >= 1 && k <= 6, k == 7, 0,
                               (k == 7) ? 2 : 1, cnt));
            #1;
            e = exp_q.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL down_guard k=%0d got=%h exp=%h", k, o, e); end
        end
        n_cmp++;
        if (din !== 32'd10 || sat_count !== 32'd10 || mode !== 3'd2 || up_down !== 1'b0) begin
            n_bad++;
            $display("FAIL down_shadow got din=%0d sat=%0d mode=%0d ud=%0d exp 10 10 2 0",
                     din, sat_count, mode, up_down);
        end
    endtask

    task automatic test_periodic();
        obs_t o, e;
        int   p, n, cnt;
        clear_irq();
        set_cfg(3, 0, 1'b1, 1'b1);
        for (int k = 0; k <= 21; k++) begin
            tick();
            start = (k == 0);
            stop  = (k == 20);
            p = (k >= 1) ? (k - 1) % 6 : 0;
            n = (k >= 1) ? (k - 1) / 6 : 0;
            if (k <= 1)       cnt = 1;
            else if (k >= 20) cnt = 0;
            else if (p == 0 || p == 5) cnt = 3;
            else              cnt = p - 1;
            exp_q.push_back(mk(k >= 1 && k <= 19 && p == 0,
                               k >= 1 && k <= 19 && p >= 1 && p <= 3,
                               k >= 1 && k <= 20, n >= 1, n >= 2, 2 + n, cnt));
            #1;
            e = exp_q.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL periodic k=%0d got=%h exp=%h", k, o, e); end
        end
        stop = 1'b0;
    endtask

    task automatic test_ack_hit();
        obs_t o, e;
        set_cfg(0, 0, 1'b1, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            tick();
            start   = (k == 0);
            irq_ack = (k == 3 || k == 4);
            exp_q.push_back(mk(k == 1, 0, k >= 1 && k <= 3, k <= 4, k <= 4,
                               (k >= 4) ? 6 : 5, 0));
            #1;
            e = exp_q.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL ack_hit k=%0d got=%h exp=%h", k, o, e); end
        end
        irq_ack = 1'b0;
    endtask

    task automatic test_stop_start();
        obs_t o, e;
        clear_irq();
        set_cfg(8, 0, 1'b1, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            tick();
            start = (k == 0 || k == 2 || k == 4);
            stop  = (k == 4);
            exp_q.push_back(mk(k == 1, k == 2 || k == 3, k >= 1 && k <= 4, 0, 0, 6,
                               (k <= 2) ? 0 : ((k == 3) ? 1 : 2)));
            #1;
            e = exp_q.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL stop_start k=%0d got=%h exp=%h", k, o, e); end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        set_cfg(20, 1, 1'b0, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            tick();
            start = (k == 0);
        end
        #1;
        n_cmp++;
        if (count !== 32'd16 || sat_count !== 32'd20 || busy !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset got cnt=%0d sat=%0d busy=%b exp 16 20 1",
                              count, sat_count, busy);
        end
        #2 reset = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL async_reset_obs got=%h exp=%h", o, e); end
        n_cmp++;
        if ({din, mode, up_down, sat_count} !== '0) begin
            n_bad++; $display("FAIL async_reset_cfg got=%h exp=0", {din, mode, up_down, sat_count});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        set_cfg(2, 0, 1'b1, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            tick();
            start = (k == 0);
            exp_q.push_back(mk(k == 1, k == 2 || k == 3, k >= 1 && k <= 5, k == 6, 0,
                               (k == 6) ? 1 : 0, (k <= 2) ? 0 : ((k == 3) ? 1 : 2)));
            #1;
            e = exp_q.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_up_oneshot();
        test_down_guard();
        test_periodic();
        test_ack_hit();
        test_stop_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
